multdiv_iterative: RTL and testbench
====================================

Name: multdiv_iterative

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage of the 5-stage pipeline.
- Started by a one-cycle control pulse from decode/execute.
- Produces a one-cycle result_ready pulse. This pulse drives the pipeline stall controller's mult_ready input and releases the multdiv stall.
- Multiply and divide share one datapath and one state machine. One operation is in flight at a time.

Parameters:
- WIDTH, 32, operand and result width. The pipeline uses 32 only; other values need not be verified.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- ctrl_mult  input  1  single-cycle start pulse for signed multiply
- ctrl_div  input  1  single-cycle start pulse for signed divide
- operand_a  input  WIDTH  multiplicand / dividend; sampled on the start edge only
- operand_b  input  WIDTH  multiplier / divisor; sampled on the start edge only
- result  output  WIDTH  low WIDTH bits of the product, or the quotient
- exception  output  1  overflow or divide-by-zero flag; valid while result_ready=1
- result_ready  output  1  one-cycle pulse; result and exception are valid in this cycle
- busy  output  1  high from the cycle after the start edge through the result_ready cycle

Behaviour:
- Reset:
  - Synchronous; wins over every other input.
  - State goes to IDLE.
  - result=0, exception=0, result_ready=0, busy=0.
  - Reset mid-operation abandons the operation; no result_ready pulse follows.
- States: IDLE, MULT, DIV, DONE.
- Start (IDLE only):
  - ctrl_mult=1 at edge E: latch operands, clear accumulator and counter, go to MULT.
  - ctrl_div=1 (ctrl_mult=0): same latch and clear, go to DIV.
  - ctrl_mult and ctrl_div both high: treated as multiply.
  - Start pulses outside IDLE are ignored. No queueing; the operand latches are unchanged.
- MULT:
  - Radix-2 Booth, one multiplier bit per cycle, 32 iterations.
  - The 64-bit accumulator holds {partial, multiplier}.
  - After the last iteration, go to DONE.
- DIV:
  - Non-restoring division on operand magnitudes, one quotient bit per cycle, 32 iterations.
  - Quotient sign = sign(a) XOR sign(b). Truncation is toward zero. The remainder is discarded.
  - operand_b==0 at the start edge: skip the iterations, go straight to DONE with result=0 and exception=1.
- DONE (one cycle):
  - result_ready=1 and busy=1.
  - Next edge returns to IDLE.
  - A start pulse present during DONE is ignored.
- Latency, with the start edge at the end of cycle 0:
  - Radix-2 multiply or normal divide: result_ready in cycle 33.
  - Divide-by-zero: result_ready in cycle 1.
- result and exception:
  - Registered; they update when entering DONE.
  - They hold their value through IDLE until the next DONE.
- Multiply exception: exception=1 when the 64-bit signed product's upper 32 bits are not the sign extension of bit 31. result is still the low 32 bits.
- Divide exception: exception=1 for divisor 0. Also exception=1 for 0x80000000 / 0xFFFFFFFF, with result=0x80000000.
- Back-to-back operation: a new start may arrive in the cycle after DONE (state is IDLE). There is no bubble requirement beyond that.

Optional Feature:
- Macro: MULTDIV_RADIX4_EN
- Defined:
  - Multiply uses radix-4 Booth recoding with 16 iterations (multiples 0, ±A, ±2A).
  - Multiply result_ready appears in cycle 17.
  - Divide is unchanged.
- Not defined: radix-2 Booth multiply with result_ready in cycle 33.
- Result and exception values are identical in both builds.

Test Plan:
- Multiply: a=7, b=-3, ctrl_mult pulse.
  - result=0xFFFFFFEB, exception=0.
  - result_ready one cycle high in cycle 33 (cycle 17 with MULTDIV_RADIX4_EN); busy high in cycles 1..33.
- Multiply overflow: a=0x00010000, b=0x00010000.
  - result=0x00000000, exception=1.
- Divide: a=-7, b=2 gives result=0xFFFFFFFD, exception=0, ready in cycle 33.
- Divide overflow: a=0x80000000, b=0xFFFFFFFF gives result=0x80000000, exception=1.
- Divide by zero: a=5, b=0, ctrl_div.
  - result_ready in cycle 1, result=0, exception=1.
- Ignored starts and reset mid-operation:
  - ctrl_div pulsed in cycle 10 of a multiply: ignored; the multiply result is unchanged.
  - reset in cycle 20 of a divide: next cycle busy=0 and no result_ready within 40 cycles.
  - A fresh ctrl_mult (a=3, b=4) after the reset completes with result=12.

Source files
------------

// File: rtl/multdiv_iterative.sv
// Iterative signed multiply/divide: Booth multiply and non-restoring divide on one shared datapath.
// Optional macro MULTDIV_RADIX4_EN selects radix-4 Booth multiply (16 iterations instead of 32).
module multdiv_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             result_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
`ifdef MULTDIV_RADIX4_EN
  localparam int MULT_ITER = WIDTH / 2;
`else
  localparam int MULT_ITER = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_MULT = CW'(MULT_ITER - 1);
  localparam logic [CW-1:0] LAST_DIV  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH+1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [WIDTH+1:0] a_ext, booth_sum, mult_hi_next;
  logic [WIDTH-1:0] mult_lo_next;
  logic             mult_qm1_next;
  logic [WIDTH-1:0] start_a_mag, b_mag;
  logic [WIDTH+1:0] div_shift, div_rem;
  logic [WIDTH-1:0] div_lo_next, div_quot;
  logic             q_neg, div_ovf;

  assign a_ext = {{2{a_q[WIDTH-1]}}, a_q};

  // Booth step: add the recoded multiple to the partial, then shift {partial, multiplier, q-1} right.
`ifdef MULTDIV_RADIX4_EN
  always_comb begin
    case ({lo_q[1:0], qm1_q})
      3'b001, 3'b010: booth_sum = hi_q + a_ext;
      3'b011:         booth_sum = hi_q + {a_ext[WIDTH:0], 1'b0};
      3'b100:         booth_sum = hi_q - {a_ext[WIDTH:0], 1'b0};
      3'b101, 3'b110: booth_sum = hi_q - a_ext;
      default:        booth_sum = hi_q;
    endcase
    mult_hi_next  = {{2{booth_sum[WIDTH+1]}}, booth_sum[WIDTH+1:2]};
    mult_lo_next  = {booth_sum[1:0], lo_q[WIDTH-1:2]};
    mult_qm1_next = lo_q[1];
  end
`else
  always_comb begin
    case ({lo_q[0], qm1_q})
      2'b01:   booth_sum = hi_q + a_ext;
      2'b10:   booth_sum = hi_q - a_ext;
      default: booth_sum = hi_q;
    endcase
    mult_hi_next  = {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
    mult_lo_next  = {booth_sum[0], lo_q[WIDTH-1:1]};
    mult_qm1_next = lo_q[0];
  end
`endif

  // Non-restoring step on magnitudes; a quotient bit is 1 whenever the new remainder is non-negative.
  assign start_a_mag = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign b_mag       = b_q[WIDTH-1] ? -b_q : b_q;
  assign div_shift   = {hi_q[WIDTH:0], lo_q[WIDTH-1]};
  assign div_rem     = hi_q[WIDTH+1] ? div_shift + {2'b00, b_mag} : div_shift - {2'b00, b_mag};
  assign div_lo_next = {lo_q[WIDTH-2:0], ~div_rem[WIDTH+1]};
  assign q_neg       = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign div_quot    = q_neg ? -div_lo_next : div_lo_next;
  assign div_ovf     = (a_q == MIN_VAL) && (b_q == {WIDTH{1'b1}});

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (ctrl_mult || ctrl_div) begin
          a_d    = operand_a;
          b_d    = operand_b;
          cnt_d  = '0;
          qm1_d  = 1'b0;
          hi_d   = '0;
          busy_d = 1'b1;
          if (ctrl_mult) begin
            lo_d    = operand_b;
            state_d = MULT;
          end else if (operand_b == '0) begin
            lo_d     = '0;
            result_d = '0;
            exc_d    = 1'b1;
            ready_d  = 1'b1;
            state_d  = DONE;
          end else begin
            lo_d    = start_a_mag;
            state_d = DIV;
          end
        end
      end
      MULT: begin
        hi_d  = mult_hi_next;
        lo_d  = mult_lo_next;
        qm1_d = mult_qm1_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_MULT) begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = mult_lo_next;
          exc_d    = (mult_hi_next[WIDTH-1:0] != {WIDTH{mult_lo_next[WIDTH-1]}});
        end
      end
      DIV: begin
        hi_d  = div_rem;
        lo_d  = div_lo_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_DIV) begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = div_quot;
          exc_d    = div_ovf;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign result       = result_q;
  assign exception    = exc_q;
  assign result_ready = ready_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_multdiv_iterative.sv
// Self-checking bench for multdiv_iterative: directed cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_multdiv_iterative;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result;
  logic        exception;
  logic        result_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef MULTDIV_RADIX4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  multdiv_iterative #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .operand_a(operand_a), .operand_b(operand_b), .result(result),
    .exception(exception), .result_ready(result_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference model: full-precision signed arithmetic.
  function automatic void ref_mult(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
    e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endfunction

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
    longint q;
    if (b == 32'd0) begin
      r = 32'd0; e = 1'b1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      r = 32'h80000000; e = 1'b1;
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = q[31:0]; e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h80000000;
      1: v = 32'hFFFFFFFF;
      2: v = 32'h7FFFFFFF;
      3: v = $urandom_range(0, 15);
      4: v = -$urandom_range(1, 15);
      5: v = $urandom_range(0, 65535);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] busy_mask(input int lat);
    logic [63:0] m;
    m = '0;
    for (int i = 1; i <= lat && i < 64; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Starts one operation at cycle 0 and observes cycles 1..63 at the falling edge.
  task automatic run_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                        input int inject_cycle, input int reset_cycle,
                        output int ready_cycle, output int pulses, output logic [31:0] res,
                        output logic exc, output logic [63:0] busy_trace, output logic [31:0] held);
    ready_cycle = -1; pulses = 0; res = '0; exc = 1'b0; busy_trace = '0;
    @(negedge clock);
    ctrl_mult = is_mult; ctrl_div = ~is_mult; operand_a = a; operand_b = b;
    for (int cyc = 1; cyc < 64; cyc++) begin
      @(negedge clock);
      ctrl_mult = 1'b0; ctrl_div = 1'b0; reset = 1'b0;
      operand_a = $urandom; operand_b = $urandom;
      busy_trace[cyc] = busy;
      if (result_ready === 1'b1) begin
        pulses++;
        if (ready_cycle < 0) begin
          ready_cycle = cyc; res = result; exc = exception;
        end
      end
      if (cyc == inject_cycle) ctrl_div = 1'b1;
      if (cyc == reset_cycle) reset = 1'b1;
    end
    held = result;
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_mult = 1'b1; ctrl_div = 1'b0; operand_a = 32'd7; operand_b = 32'd3;
    repeat (3) @(negedge clock);
    checks++;
    if ({result, exception, result_ready, busy} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got res=%h exc=%b rdy=%b busy=%b required all zero",
               result, exception, result_ready, busy);
    end
    reset = 1'b0; ctrl_mult = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || result_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got busy=%b rdy=%b required 0 0", busy, result_ready);
    end
  endtask

  task automatic test_directed(input string name, input bit is_mult, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_r, input logic exp_e,
                               input int exp_lat);
    int rc, np; logic [31:0] r, h; logic e; logic [63:0] bt;
    run_op(is_mult, a, b, 0, 0, rc, np, r, e, bt, h);
    checks++;
    if (r !== exp_r || e !== exp_e) begin
      errors++;
      $display("[TB] FAIL %s_value: got %h/%b required %h/%b", name, r, e, exp_r, exp_e);
    end
    checks++;
    if (rc !== exp_lat || np !== 1) begin
      errors++;
      $display("[TB] FAIL %s_latency: got cycle %0d pulses %0d required cycle %0d pulses 1",
               name, rc, np, exp_lat);
    end
    checks++;
    if (bt !== busy_mask(exp_lat)) begin
      errors++;
      $display("[TB] FAIL %s_busy: got %h required %h", name, bt, busy_mask(exp_lat));
    end
    checks++;
    if (h !== exp_r) begin
      errors++;
      $display("[TB] FAIL %s_hold: got %h required %h", name, h, exp_r);
    end
  endtask

  task automatic test_random(input bit is_mult, input int n);
    int rc, np, lat; logic [31:0] a, b, r, h, exp_r; logic e, exp_e; logic [63:0] bt;
    for (int i = 0; i < n; i++) begin
      a = pick_operand();
      b = pick_operand();
      if (is_mult) begin
        ref_mult(a, b, exp_r, exp_e); lat = MUL_LAT;
      end else begin
        ref_div(a, b, exp_r, exp_e); lat = (b == 32'd0) ? 1 : DIV_LAT;
      end
      run_op(is_mult, a, b, 0, 0, rc, np, r, e, bt, h);
      checks++;
      if (r !== exp_r || e !== exp_e) begin
        errors++;
        $display("[TB] FAIL rand_%s_value a=%h b=%h: got %h/%b required %h/%b",
                 is_mult ? "mul" : "div", a, b, r, e, exp_r, exp_e);
      end
      checks++;
      if (rc !== lat || np !== 1 || bt !== busy_mask(lat)) begin
        errors++;
        $display("[TB] FAIL rand_%s_timing a=%h b=%h: got cycle %0d pulses %0d busy %h required cycle %0d pulses 1 busy %h",
                 is_mult ? "mul" : "div", a, b, rc, np, bt, lat, busy_mask(lat));
      end
    end
  endtask

  task automatic test_ignored_start();
    int rc, np; logic [31:0] r, h, a, b, exp_r; logic e, exp_e; logic [63:0] bt;
    a = $urandom; b = $urandom;
    ref_mult(a, b, exp_r, exp_e);
    run_op(1'b1, a, b, 10, 0, rc, np, r, e, bt, h);
    checks++;
    if (r !== exp_r || e !== exp_e || rc !== MUL_LAT || np !== 1) begin
      errors++;
      $display("[TB] FAIL ignored_start_mult: got %h/%b cycle %0d pulses %0d required %h/%b cycle %0d pulses 1",
               r, e, rc, np, exp_r, exp_e, MUL_LAT);
    end
    run_op(1'b0, 32'd5, 32'd0, 1, 0, rc, np, r, e, bt, h);
    checks++;
    if (r !== 32'd0 || e !== 1'b1 || rc !== 1 || np !== 1 || bt !== busy_mask(1)) begin
      errors++;
      $display("[TB] FAIL ignored_start_done: got %h/%b cycle %0d pulses %0d busy %h required 0/1 cycle 1 pulses 1 busy %h",
               r, e, rc, np, bt, busy_mask(1));
    end
  endtask

  task automatic test_reset_mid_op();
    int rc, np; logic [31:0] r, h; logic e; logic [63:0] bt;
    run_op(1'b0, 32'h12345678, 32'd7, 0, 20, rc, np, r, e, bt, h);
    checks++;
    if (np !== 0 || bt !== busy_mask(20)) begin
      errors++;
      $display("[TB] FAIL reset_mid_div: got pulses %0d busy %h required pulses 0 busy %h",
               np, bt, busy_mask(20));
    end
    checks++;
    if (h !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_div_result: got %h required 00000000", h);
    end
    test_directed("after_reset_mult", 1'b1, 32'd3, 32'd4, 32'd12, 1'b0, MUL_LAT);
  endtask

  task automatic test_back_to_back();
    int first, second; logic [31:0] a1, b1, a2, b2, r1, r2, x1, x2; logic e1, e2, y1, y2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 1000);
    ref_mult(a1, b1, x1, y1);
    ref_div(a2, b2, x2, y2);
    first = -1; second = -1; r1 = '0; r2 = '0; e1 = 1'b0; e2 = 1'b0;
    @(negedge clock);
    ctrl_mult = 1'b1; operand_a = a1; operand_b = b1;
    for (int cyc = 1; cyc < 100; cyc++) begin
      @(negedge clock);
      ctrl_mult = 1'b0; ctrl_div = 1'b0;
      operand_a = $urandom; operand_b = $urandom;
      if (result_ready === 1'b1) begin
        if (first < 0) begin
          first = cyc; r1 = result; e1 = exception;
        end else if (second < 0) begin
          second = cyc; r2 = result; e2 = exception;
        end
      end
      if (first > 0 && cyc == first + 1) begin
        ctrl_div = 1'b1; operand_a = a2; operand_b = b2;
      end
    end
    checks++;
    if (first !== MUL_LAT || r1 !== x1 || e1 !== y1) begin
      errors++;
      $display("[TB] FAIL b2b_first: got cycle %0d %h/%b required cycle %0d %h/%b",
               first, r1, e1, MUL_LAT, x1, y1);
    end
    checks++;
    if (second !== MUL_LAT + 1 + DIV_LAT || r2 !== x2 || e2 !== y2) begin
      errors++;
      $display("[TB] FAIL b2b_second: got cycle %0d %h/%b required cycle %0d %h/%b",
               second, r2, e2, MUL_LAT + 1 + DIV_LAT, x2, y2);
    end
  endtask

  initial begin
    reset = 1'b1; ctrl_mult = 1'b0; ctrl_div = 1'b0; operand_a = '0; operand_b = '0;
    test_reset();
    test_directed("mult_basic", 1'b1, 32'd7, -32'd3, 32'hFFFFFFEB, 1'b0, MUL_LAT);
    test_directed("mult_ovf", 1'b1, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, MUL_LAT);
    test_directed("div_basic", 1'b0, -32'd7, 32'd2, 32'hFFFFFFFD, 1'b0, DIV_LAT);
    test_directed("div_ovf", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, DIV_LAT);
    test_directed("div_zero", 1'b0, 32'd5, 32'd0, 32'd0, 1'b1, 1);
    test_directed("mult_min", 1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, MUL_LAT);
    test_ignored_start();
    test_reset_mid_op();
    test_random(1'b1, 24);
    test_random(1'b0, 24);
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
